// File: rtl/sine_sequencer.sv
// sine_sequencer: address/quadrant generator for a quarter-wave sine sample memory.
// The read address sweeps 0..127 once per quadrant. The quadrant steps
// PEAK -> FALL -> TROUGH -> RISE. A programmable divider sets how often
// the sequence advances.
//
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset
//   enable        : advance permitted while high; all state holds while low
//   restart       : synchronous clear to the start of a period (beats enable)
//   div           : clocks per sample minus one (0 = one sample per enabled clock)
//   read_address  : quarter-table index to the memory
//   read_state    : quadrant to the memory (PEAK=00, FALL=01, TROUGH=10, RISE=11)
//   sample_strobe : one-cycle pulse when a new address/state is presented
//   sample_valid  : sample_strobe delayed one cycle, aligned with memory read data
//   period_done   : pulse when PEAK/0 is presented after the RISE/127 wrap
module sine_sequencer #(
   parameter  int unsigned DIV_WIDTH = 16,
   localparam int unsigned ADDR_W    = 7,
   localparam int unsigned QUAD_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] div,
   output logic [ADDR_W-1:0]    read_address,
   output logic [QUAD_W-1:0]    read_state,
   output logic                 sample_strobe,
   output logic                 sample_valid,
   output logic                 period_done
);

   typedef enum logic [QUAD_W-1:0] {
      PEAK   = 2'b00,
      FALL   = 2'b01,
      TROUGH = 2'b10,
      RISE   = 2'b11
   } quad_e;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   logic [DIV_WIDTH-1:0] tick_cnt;
   logic [DIV_WIDTH-1:0] tick_d;
   logic [ADDR_W-1:0]    addr_d;
   quad_e                quad_q;
   quad_e                quad_d;
   logic                 strobe_d;
   logic                 done_d;

   assign read_state = quad_q;

   // Next-state: restart beats enable; >= lets a lowered div advance at once.
   always_comb begin
      tick_d   = tick_cnt;
      addr_d   = read_address;
      quad_d   = quad_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      if (restart) begin
         tick_d = '0;
         addr_d = '0;
         quad_d = PEAK;
      end else if (enable) begin
         if (tick_cnt >= div) begin
            tick_d   = '0;
            strobe_d = 1'b1;
            if (read_address == ADDR_LAST) begin
               addr_d = '0;
               done_d = (quad_q == RISE);
               case (quad_q)
                  PEAK:    quad_d = FALL;
                  FALL:    quad_d = TROUGH;
                  TROUGH:  quad_d = RISE;
                  default: quad_d = PEAK;
               endcase
            end else begin
               addr_d = read_address + ADDR_W'(1);
            end
         end else begin
            tick_d = tick_cnt + DIV_WIDTH'(1);
         end
      end
   end

   // State register; sample_valid tracks the strobe even through restart/disable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt      <= '0;
         read_address  <= '0;
         quad_q        <= PEAK;
         sample_strobe <= 1'b0;
         sample_valid  <= 1'b0;
         period_done   <= 1'b0;
      end else begin
         tick_cnt      <= tick_d;
         read_address  <= addr_d;
         quad_q        <= quad_d;
         sample_strobe <= strobe_d;
         sample_valid  <= sample_strobe;
         period_done   <= done_d;
      end
   end

endmodule

// File: doc/sine_sequencer.md
# sine_sequencer

Generates the address/quadrant sequence that drives the quarter-wave sine sample memory: a 7-bit `read_address` that sweeps 0..127 in every quadrant, and a 2-bit `read_state` cycling PEAK→FALL→TROUGH→RISE. The block sits directly upstream of the sample memory. A programmable clock divider sets the sample rate. Strobes mark each new address and the matching valid memory output one cycle later, for the DAC stage.

## Interface
- `DIV_WIDTH`, default 16: width of the divider input and the internal tick counter.
- `clk` input 1: the single system clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `enable` input 1: advance permitted while high; all state holds while low.
- `restart` input 1: synchronous clear to the start of a period; has priority over `enable`.
- `div` input DIV_WIDTH: clocks per sample minus one; 0 means one sample per enabled clock.
- `read_address` output 7: quarter-table index to the memory.
- `read_state` output 2: quadrant to the memory. PEAK=00, FALL=01, TROUGH=10, RISE=11.
- `sample_strobe` output 1: one-cycle pulse, high in the cycle a new address/state is presented.
- `sample_valid` output 1: `sample_strobe` delayed one cycle; aligns with the memory's registered `read_data`.
- `period_done` output 1: one-cycle pulse, high in the cycle the sequence is presented at PEAK/0 after the RISE/127 wrap.

## Operation
- Registers: `tick_cnt[DIV_WIDTH-1:0]`, `read_address`, `read_state`, `sample_strobe`, `sample_valid`, `period_done`.
- Priority per edge is `rst_n` low, then `restart`, then `enable`, then hold.
- **Reset (`rst_n`=0):** all registers clear to 0. Outputs read address 0, state PEAK, all strobes low.
- **Restart (`restart`=1, `rst_n`=1):**
  - `tick_cnt`, address and state clear to 0.
  - `sample_strobe` and `period_done` are 0.
  - `sample_valid` still takes the previous `sample_strobe`.
- **Enabled tick (`enable`=1):**
  - If `tick_cnt >= div`: `tick_cnt` goes to 0 and the block advances.
  - Otherwise `tick_cnt` increments.
  - The `>=` compare means a `div` reduced below the current count causes an advance on the next enabled edge, with no wrap through 2^DIV_WIDTH.
- **Advance:**
  - If address < 127, address increments and state is unchanged.
  - If address = 127, address goes to 0 and state steps PEAK→FALL→TROUGH→RISE→PEAK (2-bit wrap).
  - `sample_strobe` is 1 on an advance and 0 otherwise.
  - `period_done` is 1 only on the advance from RISE/127 to PEAK/0.
- **Address direction:** the address always counts up. The memory mirrors it for FALL and RISE.
- **Disabled (`enable`=0):** `tick_cnt`, address and state hold. `sample_strobe` and `period_done` are 0. `sample_valid` still tracks the delayed strobe.
- **`div` sampling:** `div` is sampled every cycle and is not latched. A change takes effect at the next compare.
- **Reset mid-operation:** takes effect on the next edge regardless of `enable`, `restart` or counter value.

## Timing
- **Advance cadence:** one advance every `div`+1 enabled cycles.
- **Full period:** 512 advances, i.e. 512·(`div`+1) enabled cycles.
- **First advance:** from reset or restart, the first advance occurs on enabled edge number `div`+1.
- **Output latency:** address, state, `sample_strobe` and `period_done` change together, registered on the advance edge, with zero added latency between them.
- **`sample_valid`:** exactly one cycle after `sample_strobe`, matching the memory's one-cycle read latency.
- **Pulse width:** strobes are never wider than one cycle unless `div`=0 with `enable` held. In that case `sample_strobe` and `sample_valid` stay high continuously.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `enable`=1 and `div`=0 → address 0, state 00, all strobes 0. Release → first advance to address 1 on the next edge.
- **Full sweep, `div`=0, `enable`=1:**
  - After 127 edges: address 127, state 00.
  - Edge 128: address 0, state 01.
  - Edge 512: address 0, state 00 with `period_done`=1 for exactly that cycle.
  - `sample_valid` is continuously 1 from edge 2.
- **Cadence, `div`=3:** `sample_strobe` pulses every 4th cycle. `sample_valid` pulses one cycle later. A full period takes 2048 cycles.
- **Enable gating, `div`=3:** drop `enable` for 10 cycles when `tick_cnt`=2 → address and count frozen, no strobes. After re-enable, the advance occurs on the 2nd enabled edge.
- **Restart:** at state TROUGH address 50, assert `restart` together with `enable` → next cycle address 0, state 00, `tick_cnt` 0, no `period_done`.
- **Divider reduction:** at `div`=100 with `tick_cnt`=60, set `div`=10 → advance on the next edge, then every 11 cycles.
